// File: rtl/writeback_stage_if.sv
// Memory-stage to write-back bus: captured instruction fields in, register-file write port and status out.
// Optional WB_FWD_EN adds the forwarding copy of the last strobed write.
interface writeback_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    logic              i_valid;
    logic              i_stall;
    logic              i_flush;
    logic              i_write_back;
    logic [1:0]        i_wb_selector;
    logic              i_output_port;
    logic [ADDR_W-1:0] i_rd;
    logic [DATA_W-1:0] i_alu_result;
    logic [DATA_W-1:0] i_mem_data;
    logic [DATA_W-1:0] i_in_port;
    logic [DATA_W-1:0] i_imm;
    logic              o_write_back;
    logic [ADDR_W-1:0] o_write_addr;
    logic [DATA_W-1:0] o_write_data;
    logic [DATA_W-1:0] o_out_port;
    logic [CNT_W-1:0]  o_retired;
`ifdef WB_FWD_EN
    logic              o_fwd_valid;
    logic [ADDR_W-1:0] o_fwd_addr;
    logic [DATA_W-1:0] o_fwd_data;
`endif

    modport master (
`ifdef WB_FWD_EN
        input  o_fwd_valid, o_fwd_addr, o_fwd_data,
`endif
        output i_valid, i_stall, i_flush, i_write_back, i_wb_selector, i_output_port,
        output i_rd, i_alu_result, i_mem_data, i_in_port, i_imm,
        input  o_write_back, o_write_addr, o_write_data, o_out_port, o_retired
    );

    modport slave (
`ifdef WB_FWD_EN
        output o_fwd_valid, o_fwd_addr, o_fwd_data,
`endif
        input  i_valid, i_stall, i_flush, i_write_back, i_wb_selector, i_output_port,
        input  i_rd, i_alu_result, i_mem_data, i_in_port, i_imm,
        output o_write_back, o_write_addr, o_write_data, o_out_port, o_retired
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, write-back mux, register-file write port, output port, retire count.
// Define WB_FWD_EN to add the one-cycle-delayed forwarding copy of the strobed write.
module writeback_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    writeback_stage_if.slave bus
);
    logic              r_valid;
    logic              r_wb;
    logic              r_op;
    logic              r_first;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_sel;
    logic [DATA_W-1:0] r_out_port;
    logic [CNT_W-1:0]  r_retired;
    logic [DATA_W-1:0] w_sel;
    logic              w_strobe;
    logic              w_done;

    always_comb begin
        w_sel = bus.i_alu_result;
        case (bus.i_wb_selector)
            2'b00:   w_sel = bus.i_alu_result;
            2'b01:   w_sel = bus.i_mem_data;
            2'b10:   w_sel = bus.i_in_port;
            default: w_sel = bus.i_imm;
        endcase
    end

    // An entry retires once, at the end of its first cycle in the stage; stalled repeats never strobe.
    assign w_strobe = r_valid & r_wb & r_first;
    assign w_done   = r_valid & r_first;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_valid    <= 1'b0;
            r_wb       <= 1'b0;
            r_op       <= 1'b0;
            r_first    <= 1'b0;
            r_rd       <= '0;
            r_sel      <= '0;
            r_out_port <= '0;
            r_retired  <= '0;
        end else begin
            if (w_done) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_op) r_out_port <= r_sel;
            end
            if (bus.i_flush) begin
                r_valid <= 1'b0;
                r_wb    <= 1'b0;
                r_op    <= 1'b0;
                r_first <= 1'b0;
            end else if (bus.i_stall) begin
                r_first <= 1'b0;
            end else begin
                r_valid <= bus.i_valid;
                r_wb    <= bus.i_write_back;
                r_op    <= bus.i_output_port;
                r_rd    <= bus.i_rd;
                r_sel   <= w_sel;
                r_first <= 1'b1;
            end
        end
    end

    assign bus.o_write_back = w_strobe;
    assign bus.o_write_addr = r_rd;
    assign bus.o_write_data = r_sel;
    assign bus.o_out_port   = r_out_port;
    assign bus.o_retired    = r_retired;

`ifdef WB_FWD_EN
    logic              r_fwd_valid;
    logic [ADDR_W-1:0] r_fwd_addr;
    logic [DATA_W-1:0] r_fwd_data;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= w_strobe & ~bus.i_flush;
            r_fwd_addr  <= r_rd;
            r_fwd_data  <= r_sel;
        end
    end

    assign bus.o_fwd_valid = r_fwd_valid;
    assign bus.o_fwd_addr  = r_fwd_addr;
    assign bus.o_fwd_data  = r_fwd_data;
`endif
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage; the producer side of the register-file write port that the decode stage consumes.
- Registers MEM/WB results and selects the write-back value with the 2-bit write-back selector.
- Drives the write strobe, address and data into decode's write port, latches the output port, and counts retired instructions.
- Sits between the memory stage and decode_stage's i_write_back / i_write_addr / i_write_data inputs.

Parameters:
DATA_W, 16, datapath width
ADDR_W, 3, register address width
CNT_W, 16, retired-instruction counter width

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-low reset (0 = reset)
i_valid  in  1  memory stage presents a valid instruction
i_stall  in  1  hold MEM/WB register contents
i_flush  in  1  replace the entry being captured with a bubble
i_write_back  in  1  instruction writes a register
i_wb_selector  in  2  00 ALU result, 01 memory data, 10 input port, 11 immediate
i_output_port  in  1  instruction writes the output port
i_rd  in  ADDR_W  destination register
i_alu_result  in  DATA_W  ALU result
i_mem_data  in  DATA_W  memory read data
i_in_port  in  DATA_W  external input port
i_imm  in  DATA_W  immediate / shift amount
o_write_back  out  1  register-file write strobe
o_write_addr  out  ADDR_W  register-file write address
o_write_data  out  DATA_W  register-file write data
o_out_port  out  DATA_W  external output port, held value
o_retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (i_reset=0 at a rising edge):
  - All outputs go to 0 and the entry valid bit clears.
  - This overrides stall and flush, and an in-flight entry is discarded.
- Priority at each edge: reset > flush > stall > capture.
- Capture (no stall, no flush):
  - Register the valid bit, write_back, rd, output_port and the selected value sel.
  - sel is mux(i_wb_selector) evaluated at the capture edge, so i_in_port is sampled at that edge.
  - Latency: one cycle from memory-stage inputs to o_write_*.
- o_write_back = entry valid AND registered write_back AND first_cycle.
  - first_cycle is set on every capture and cleared after one cycle of stall.
  - A stalled entry therefore strobes the write exactly once and never re-writes.
- o_write_addr and o_write_data show the registered rd and sel continuously, including while stalled.
- Flush (i_flush=1, reset inactive):
  - Entry valid clears and o_write_back=0 on the next cycle.
  - Flush overrides stall; the held entry is lost (it already strobed in its first cycle).
- Output port:
  - When a captured entry has valid=1 and output_port=1, o_out_port loads sel one cycle after capture.
  - The value holds until the next such entry or reset.
  - Stall does not reload it.
- Retired counter:
  - Increments by 1 on each cycle where a valid entry completes its first cycle, whether or not it writes back.
  - Wraps from 2^CNT_W-1 to 0.
  - Bubbles, flushed entries and stalled repeat cycles do not count.
- i_valid=0 captures a bubble: no strobe, no count, no port update.
- Back-to-back writes to the same rd each strobe in their own cycle; the later value wins in the register file.

Optional Feature:
WB_FWD_EN
- Defined: adds outputs o_fwd_valid (1), o_fwd_addr (ADDR_W) and o_fwd_data (DATA_W).
  - These register the previous cycle's strobed write, held for one extra cycle, so the execute-stage forwarding unit can cover the write-then-read window.
  - o_fwd_valid clears on reset and on flush.
- Not defined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold i_reset=0 for 2 cycles with i_valid=1 → o_write_back=0, o_out_port=0, o_retired=0; release → first capture strobes one cycle later.
- Selector sweep: rd=5 with sel 00/01/10/11 and alu=0x1111, mem=0x2222, in=0x3333, imm=0x0044 → o_write_addr=5 and o_write_data=0x1111, 0x2222, 0x3333, 0x0044 on consecutive cycles; o_retired=4.
- Stall: capture rd=2, data 0xBEEF, then i_stall=1 for 3 cycles → o_write_back high for exactly 1 cycle, data held at 0xBEEF, o_retired +1 only.
- Flush priority: i_flush=1 together with i_stall=1 and i_valid=1 → next cycle o_write_back=0 and no count.
- Output port: output_port=1, write_back=0, alu=0x00A5 → o_out_port=0x00A5 after one cycle and held through 5 bubbles; no register strobe.
- Counter wrap (CNT_W=4): 17 valid instructions → o_retired=1.
